key_event_arbiter: RTL and testbench

Merges three keyboard-event requesters into one registered event stream that feeds the ZX matrix and the scancode FIFO. The requesters are the PS/2 key input, the joystick 1 change scanner and the joystick 2 change scanner. Joystick bit changes are translated into PS/2 set-2 codes according to the per-port mode. Requesters are served round-robin; the output uses a valid/ready handshake with backpressure.

---
 rtl/key_event_arbiter_if.sv | 12 +
 rtl/key_event_arbiter.sv | 152 +++++++++++++++
 tb/tb_key_event_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_arbiter_if.sv
// Registered key-event stream: producer drives the event fields and valid,
// consumer drives ready.
interface key_event_arbiter_if;
    logic       ev_valid;
    logic       ev_press;
    logic [8:0] ev_code;
    logic [1:0] ev_src;
    logic       ev_ready;

    modport master (output ev_valid, ev_press, ev_code, ev_src, input ev_ready);
    modport slave  (input ev_valid, ev_press, ev_code, ev_src, output ev_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Merges the PS/2 key input and two joystick change scanners into one
// round-robin arbitrated, registered key event stream with backpressure.
module key_event_arbiter #(
    parameter int unsigned JOY_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [10:0]           ps2_key,
    input  logic [JOY_BITS-1:0]   joystick1,
    input  logic [JOY_BITS-1:0]   joystick2,
    input  logic [1:0]            cfg_joystick1,
    input  logic [1:0]            cfg_joystick2,
    key_event_arbiter_if.master   ev,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    typedef enum logic [1:0] {
        SRC_PS2  = 2'd0,
        SRC_JOY1 = 2'd1,
        SRC_JOY2 = 2'd2
    } src_e;

    // Joystick bit -> PS/2 set-2 code; bit 8 marks an extended (E0) code.
    function automatic logic [8:0] joy_code(input logic [1:0] mode, input logic [2:0] idx);
        logic [8:0] c;
        c = '0;
        case (mode)
            2'b01: case (idx)
                3'd0: c = 9'h03d; 3'd1: c = 9'h036; 3'd2: c = 9'h03e; 3'd3: c = 9'h046;
                3'd4: c = 9'h045; 3'd5: c = 9'h03a; 3'd6: c = 9'h031; default: c = 9'h032;
            endcase
            2'b10: case (idx)
                3'd0: c = 9'h01e; 3'd1: c = 9'h016; 3'd2: c = 9'h026; 3'd3: c = 9'h025;
                3'd4: c = 9'h02e; 3'd5: c = 9'h01a; 3'd6: c = 9'h022; default: c = 9'h021;
            endcase
            2'b11: case (idx)
                3'd0: c = 9'h174; 3'd1: c = 9'h16b; 3'd2: c = 9'h172; 3'd3: c = 9'h175;
                3'd4: c = 9'h05a; 3'd5: c = 9'h00d; 3'd6: c = 9'h029; default: c = 9'h076;
            endcase
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] lowest_diff(input logic [JOY_BITS-1:0] d);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = JOY_BITS; i > 0; i--)
            if (d[i-1]) idx = 3'(i - 1);
        return idx;
    endfunction

    logic                tog_r;
    logic                slot_full;
    logic                slot_press;
    logic [8:0]          slot_code;
    logic [JOY_BITS-1:0] joys_r1, joys_r2;
    src_e                rr;

    logic [2:0]          cand1, cand2;
    logic [2:0]          req;
    logic                can_grant, grant, ps2_new, ps2_lost;
    logic [1:0]          s;
    src_e                win;
    logic                g_press;
    logic [8:0]          g_code;

    always_comb begin
        cand1    = lowest_diff(joystick1 ^ joys_r1);
        cand2    = lowest_diff(joystick2 ^ joys_r2);
        req[0]   = slot_full;
        req[1]   = (cfg_joystick1 != 2'b00) && (joystick1 != joys_r1);
        req[2]   = (cfg_joystick2 != 2'b00) && (joystick2 != joys_r2);
        ps2_new  = ps2_key[10] ^ tog_r;

        can_grant = !ev.ev_valid || ev.ev_ready;
        grant     = 1'b0;
        win       = rr;
        s         = '0;
        // Search starts one past the last winner and wraps modulo 3.
        for (int unsigned k = 1; k <= 3; k++) begin
            s = 2'((32'(rr) + k) % 3);
            if (!grant && can_grant && req[s]) begin
                grant = 1'b1;
                win   = src_e'(s);
            end
        end

        case (win)
            SRC_JOY1: begin g_press = joystick1[cand1]; g_code = joy_code(cfg_joystick1, cand1); end
            SRC_JOY2: begin g_press = joystick2[cand2]; g_code = joy_code(cfg_joystick2, cand2); end
            default:  begin g_press = slot_press;       g_code = slot_code;                       end
        endcase

        // A slot freed by this cycle's grant can take the new event.
        ps2_lost = ps2_new && slot_full && !(grant && win == SRC_PS2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_r       <= 1'b0;
            slot_full   <= 1'b0;
            slot_press  <= 1'b0;
            slot_code   <= '0;
            joys_r1     <= '0;
            joys_r2     <= '0;
            rr          <= SRC_PS2;
            overrun     <= 1'b0;
            ev.ev_valid <= 1'b0;
            ev.ev_press <= 1'b0;
            ev.ev_code  <= '0;
            ev.ev_src   <= '0;
        end else begin
            tog_r <= ps2_key[10];

            if (ps2_new && !ps2_lost) begin
                slot_full  <= 1'b1;
                slot_press <= ps2_key[9];
                slot_code  <= ps2_key[8:0];
            end else if (grant && win == SRC_PS2) begin
                slot_full  <= 1'b0;
            end

            if (ps2_lost)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            if (cfg_joystick1 == 2'b00)
                joys_r1 <= joystick1;
            else if (grant && win == SRC_JOY1)
                joys_r1[cand1] <= joystick1[cand1];

            if (cfg_joystick2 == 2'b00)
                joys_r2 <= joystick2;
            else if (grant && win == SRC_JOY2)
                joys_r2[cand2] <= joystick2[cand2];

            if (grant) begin
                rr          <= win;
                ev.ev_valid <= 1'b1;
                ev.ev_press <= g_press;
                ev.ev_code  <= g_code;
                ev.ev_src   <= win;
            end else if (ev.ev_ready) begin
                ev.ev_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the event merger.
module tb_key_event_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [7:0]  joystick1, joystick2;
    logic [1:0]  cfg_joystick1, cfg_joystick2;
    logic        overrun, overrun_clr;

    key_event_arbiter_if ev_if ();

    key_event_arbiter #(.JOY_BITS(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_key       (ps2_key),
        .joystick1     (joystick1),
        .joystick2     (joystick2),
        .cfg_joystick1 (cfg_joystick1),
        .cfg_joystick2 (cfg_joystick2),
        .ev            (ev_if),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Mapping table per mode (row 0 unused); bit 8 = extended.
    bit [8:0] tbl [4][8] = '{
        '{default: 9'h000},
        '{9'h03d, 9'h036, 9'h03e, 9'h046, 9'h045, 9'h03a, 9'h031, 9'h032},
        '{9'h01e, 9'h016, 9'h026, 9'h025, 9'h02e, 9'h01a, 9'h022, 9'h021},
        '{9'h174, 9'h16b, 9'h172, 9'h175, 9'h05a, 9'h00d, 9'h029, 9'h076}
    };

    bit        m_valid, m_press, m_ovr, m_tog;
    bit [8:0]  m_code;
    int        m_src, m_win;
    bit [9:0]  m_slot [$];
    bit [7:0]  m_last [2];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_press = 0; m_code = '0; m_src = 0; m_ovr = 0;
        m_tog = 0; m_win = 0; m_last[0] = '0; m_last[1] = '0;
        m_slot.delete();
    endtask

    // Predicts the state the DUT reaches at the coming clock edge.
    task automatic model_step();
        bit [7:0] joy [2];
        bit [1:0] cfg [2];
        bit       req [3];
        int       first [2];
        int       win;
        bit       g_press, newp, lost;
        bit [8:0] g_code;
        joy[0] = joystick1;     joy[1] = joystick2;
        cfg[0] = cfg_joystick1; cfg[1] = cfg_joystick2;
        req[0] = (m_slot.size() != 0);
        for (int p = 0; p < 2; p++) begin
            first[p] = -1;
            for (int b = 0; b < 8; b++)
                if (first[p] < 0 && joy[p][b] != m_last[p][b]) first[p] = b;
            req[p+1] = (cfg[p] != 0) && (first[p] >= 0);
        end
        win = -1;
        if (!m_valid || ev_if.ev_ready)
            for (int k = 1; k <= 3; k++)
                if (win < 0 && req[(m_win + k) % 3]) win = (m_win + k) % 3;
        g_press = 0; g_code = '0;
        if (win == 0) begin
            {g_press, g_code} = m_slot.pop_front();
        end else if (win > 0) begin
            g_press = joy[win-1][first[win-1]];
            g_code  = tbl[cfg[win-1]][first[win-1]];
        end
        newp  = (ps2_key[10] != m_tog);
        m_tog = ps2_key[10];
        lost  = newp && (m_slot.size() != 0);
        if (newp && !lost) m_slot.push_back(ps2_key[9:0]);
        if (lost) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        for (int p = 0; p < 2; p++) begin
            if (cfg[p] == 0) m_last[p] = joy[p];
            else if (win == p + 1) m_last[p][first[p]] = joy[p][first[p]];
        end
        if (win >= 0) begin
            m_valid = 1; m_press = g_press; m_code = g_code; m_src = win; m_win = win;
        end else if (ev_if.ev_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid", 16'(ev_if.ev_valid), 16'(m_valid));
        if (m_valid) begin
            check("press", 16'(ev_if.ev_press), 16'(m_press));
            check("code",  16'(ev_if.ev_code),  16'(m_code));
            check("src",   16'(ev_if.ev_src),   16'(m_src));
        end
        check("overrun", 16'(overrun), 16'(m_ovr));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ps2_ev(input bit press, input bit [8:0] code);
        ps2_key = {~ps2_key[10], press, code};
    endtask

    task automatic rand_inputs(input int p_ps2, input int p_joy, input int p_rdy);
        int j;
        if ($urandom_range(99) < p_ps2) ps2_key = {~ps2_key[10], 10'($urandom)};
        else                            ps2_key[9:0] = 10'($urandom);
        if ($urandom_range(99) < p_joy) begin j = $urandom_range(7); joystick1[j] = ~joystick1[j]; end
        if ($urandom_range(99) < p_joy) begin j = $urandom_range(7); joystick2[j] = ~joystick2[j]; end
        ev_if.ev_ready = ($urandom_range(99) < p_rdy);
        overrun_clr    = ($urandom_range(9) == 0);
        if ($urandom_range(39) == 0) cfg_joystick1 = 2'($urandom);
        if ($urandom_range(39) == 0) cfg_joystick2 = 2'($urandom);
    endtask

    initial begin
        reset_n = 1'b0;
        ps2_key = '0; joystick1 = '0; joystick2 = '0;
        cfg_joystick1 = 2'b00; cfg_joystick2 = 2'b00;
        overrun_clr = 1'b0; ev_if.ev_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_valid",   16'(ev_if.ev_valid), 16'h0);
        check("reset_code",    16'(ev_if.ev_code),  16'h0);
        check("reset_overrun", 16'(overrun),        16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin: joy1 first (rr starts at PS/2), then joy2, then PS/2.
        ev_if.ev_ready = 1'b0;
        ps2_ev(1'b1, 9'h05a);
        cfg_joystick1 = 2'b01; joystick1 = 8'h10;
        cfg_joystick2 = 2'b10; joystick2 = 8'h10;
        step(); check("rr1_code", 16'(ev_if.ev_code), 16'h045); check("rr1_src", 16'(ev_if.ev_src), 16'h1);
        step(); check("rr_hold", 16'(ev_if.ev_code), 16'h045);
        ev_if.ev_ready = 1'b1;
        step(); check("rr2_code", 16'(ev_if.ev_code), 16'h02e); check("rr2_src", 16'(ev_if.ev_src), 16'h2);
        step(); check("rr3_code", 16'(ev_if.ev_code), 16'h05a); check("rr3_src", 16'(ev_if.ev_src), 16'h0);
        step(); check("rr_empty", 16'(ev_if.ev_valid), 16'h0);

        // PS/2 latency: toggle seen at edge n, valid after edge n+1.
        ps2_ev(1'b1, 9'h01c);
        step(); check("lat_early", 16'(ev_if.ev_valid), 16'h0);
        step(); check("lat_valid", 16'(ev_if.ev_valid), 16'h1); check("lat_code", 16'(ev_if.ev_code), 16'h01c);
        step(); check("lat_once", 16'(ev_if.ev_valid), 16'h0);

        // Cursor mapping on joystick 1 bit 0, make then break.
        cfg_joystick1 = 2'b11; joystick1 = 8'h11;
        step(); check("cur_make", 16'(ev_if.ev_code), 16'h174); check("cur_press", 16'(ev_if.ev_press), 16'h1);
        joystick1 = 8'h10;
        step(); check("cur_brk", 16'(ev_if.ev_code), 16'h174); check("cur_rel", 16'(ev_if.ev_press), 16'h0);
        step();

        // Backpressure and overrun: third event lost while slot is full.
        ev_if.ev_ready = 1'b0;
        ps2_ev(1'b1, 9'h011); step(); step();
        ps2_ev(1'b1, 9'h012); step();
        ps2_ev(1'b1, 9'h013); step(); check("ovr_set", 16'(overrun), 16'h1);
        step();
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_clr", 16'(overrun), 16'h0);
        ev_if.ev_ready = 1'b1;
        step(); check("bp_next", 16'(ev_if.ev_code), 16'h012);
        step(); check("bp_lost", 16'(ev_if.ev_valid), 16'h0);

        // Glitch absorb: bit0 returns before grant, only bit3 make survives.
        ev_if.ev_ready = 1'b0; cfg_joystick2 = 2'b01;
        ps2_ev(1'b0, 9'h0aa); step(); step();
        joystick2 = 8'h19; step();
        joystick2 = 8'h18; step();
        ev_if.ev_ready = 1'b1;
        step(); check("glitch_code", 16'(ev_if.ev_code), 16'h046); check("glitch_src", 16'(ev_if.ev_src), 16'h2);
        step(); check("glitch_once", 16'(ev_if.ev_valid), 16'h0);

        // Mode off: joystick activity raises nothing.
        cfg_joystick1 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            joystick1 = 8'($urandom);
            step(); check("mode_off", 16'(ev_if.ev_valid), 16'h0);
        end

        // Reset while an event is held and overrun is set.
        ev_if.ev_ready = 1'b0;
        ps2_ev(1'b1, 9'h021); step(); step();
        ps2_ev(1'b1, 9'h022); step();
        ps2_ev(1'b1, 9'h023); step();
        #3 reset_n = 1'b0;
        #1;
        check("rst_valid",   16'(ev_if.ev_valid), 16'h0);
        check("rst_overrun", 16'(overrun),        16'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic across load profiles.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 400; c++) begin
                case (ph)
                    0:       rand_inputs(30, 30, 100);
                    1:       rand_inputs(40, 40, 20);
                    2:       rand_inputs(10, 60, 70);
                    default: rand_inputs(50, 20, 50);
                endcase
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
